md_sched: RTL and testbench

Scheduler for the shared multiply/divide unit in the out-of-order core. Arbitrates between the MUL and DIV reservation stations, which dispatch operations decoded with `RS_ENT_MUL` / `RS_ENT_DIV`. It issues one operation at a time to the MD unit over a valid/ready handshake, captures the result, and broadcasts it on the common data bus (CDB) with the originating tag. There is at most one operation in flight.

---
 rtl/md_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_md_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// rtl/md_sched.sv - Multiply/divide unit scheduler: MUL/DIV arbitration, MD issue, CDB broadcast
//
// Purpose:
//   Picks one operation at a time from the MUL and DIV reservation stations,
//   issues it to the shared multiply/divide unit over a valid/ready handshake,
//   captures the result and broadcasts it on the common data bus with the
//   originating tag. At most one operation is in flight.
//
// Configuration:
//   MD_SCHED_RR_EN defined   : round-robin between MUL and DIV; the pointer
//                              moves only on acceptance and resets to
//                              "MUL granted last" so DIV wins the first tie.
//   MD_SCHED_RR_EN undefined : fixed priority, MUL over DIV; no pointer.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   busy                     high whenever the FSM is not IDLE
//   mul_* / div_*            requester sets: valid/ready handshake, op,
//                            operand signedness, out_sel, operands, tag
//   md_req_*                 request to the MD unit (valid/ready), driven
//                            from the holding registers
//   md_resp_valid/_result    MD unit response (honoured in ISSUE/WAIT only)
//   cdb_req/gnt/tag/data     CDB broadcast, held until granted

module md_sched #(
    parameter int TAG_W            = 4,
    parameter int XLEN             = 32,
    parameter int MD_OP_WIDTH      = 3,
    parameter int MD_OUT_SEL_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        busy,

    input  logic                        mul_valid,
    output logic                        mul_ready,
    input  logic [MD_OP_WIDTH-1:0]      mul_op,
    input  logic                        mul_in_1_signed,
    input  logic                        mul_in_2_signed,
    input  logic [MD_OUT_SEL_WIDTH-1:0] mul_out_sel,
    input  logic [XLEN-1:0]             mul_a,
    input  logic [XLEN-1:0]             mul_b,
    input  logic [TAG_W-1:0]            mul_tag,

    input  logic                        div_valid,
    output logic                        div_ready,
    input  logic [MD_OP_WIDTH-1:0]      div_op,
    input  logic                        div_in_1_signed,
    input  logic                        div_in_2_signed,
    input  logic [MD_OUT_SEL_WIDTH-1:0] div_out_sel,
    input  logic [XLEN-1:0]             div_a,
    input  logic [XLEN-1:0]             div_b,
    input  logic [TAG_W-1:0]            div_tag,

    output logic                        md_req_valid,
    input  logic                        md_req_ready,
    output logic [MD_OP_WIDTH-1:0]      md_req_op,
    output logic                        md_req_in_1_signed,
    output logic                        md_req_in_2_signed,
    output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
    output logic [XLEN-1:0]             md_req_in_1,
    output logic [XLEN-1:0]             md_req_in_2,
    input  logic                        md_resp_valid,
    input  logic [XLEN-1:0]             md_resp_result,

    output logic                        cdb_req,
    input  logic                        cdb_gnt,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [XLEN-1:0]             cdb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        BCAST = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [MD_OP_WIDTH-1:0]      op_q, op_d;
    logic                        in_1_signed_q, in_1_signed_d;
    logic                        in_2_signed_q, in_2_signed_d;
    logic [MD_OUT_SEL_WIDTH-1:0] out_sel_q, out_sel_d;
    logic [XLEN-1:0]             in_1_q, in_1_d;
    logic [XLEN-1:0]             in_2_q, in_2_d;
    logic [TAG_W-1:0]            tag_q, tag_d;
    logic [XLEN-1:0]             result_q, result_d;

    logic                        pick_div;
    logic                        any_valid;

`ifdef MD_SCHED_RR_EN
    // 1 = DIV was granted last, 0 = MUL was granted last.
    logic                        last_div_q, last_div_d;
`endif

    // Arbitration: which requester would be accepted this cycle in IDLE.
    always_comb begin
        any_valid = mul_valid | div_valid;
`ifdef MD_SCHED_RR_EN
        if (mul_valid && div_valid) begin
            pick_div = ~last_div_q;
        end else begin
            pick_div = div_valid;
        end
`else
        pick_div = div_valid & ~mul_valid;
`endif
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        in_1_signed_d = in_1_signed_q;
        in_2_signed_d = in_2_signed_q;
        out_sel_d     = out_sel_q;
        in_1_d        = in_1_q;
        in_2_d        = in_2_q;
        tag_d         = tag_q;
        result_d      = result_q;
`ifdef MD_SCHED_RR_EN
        last_div_d    = last_div_q;
`endif
        mul_ready     = 1'b0;
        div_ready     = 1'b0;
        md_req_valid  = 1'b0;
        cdb_req       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The ready goes only to a valid requester, so any_valid
                // already implies a completed handshake.
                if (any_valid) begin
                    mul_ready = ~pick_div;
                    div_ready = pick_div;
                    if (pick_div) begin
                        op_d          = div_op;
                        in_1_signed_d = div_in_1_signed;
                        in_2_signed_d = div_in_2_signed;
                        out_sel_d     = div_out_sel;
                        in_1_d        = div_a;
                        in_2_d        = div_b;
                        tag_d         = div_tag;
                    end else begin
                        op_d          = mul_op;
                        in_1_signed_d = mul_in_1_signed;
                        in_2_signed_d = mul_in_2_signed;
                        out_sel_d     = mul_out_sel;
                        in_1_d        = mul_a;
                        in_2_d        = mul_b;
                        tag_d         = mul_tag;
                    end
`ifdef MD_SCHED_RR_EN
                    last_div_d = pick_div;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                md_req_valid = 1'b1;
                if (md_req_ready) begin
                    // A unit that answers in the accepting cycle skips WAIT.
                    if (md_resp_valid) begin
                        result_d = md_resp_result;
                        state_d  = BCAST;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (md_resp_valid) begin
                    result_d = md_resp_result;
                    state_d  = BCAST;
                end
            end
            BCAST: begin
                cdb_req = 1'b1;
                if (cdb_gnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            in_1_signed_q <= 1'b0;
            in_2_signed_q <= 1'b0;
            out_sel_q     <= '0;
            in_1_q        <= '0;
            in_2_q        <= '0;
            tag_q         <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            in_1_signed_q <= in_1_signed_d;
            in_2_signed_q <= in_2_signed_d;
            out_sel_q     <= out_sel_d;
            in_1_q        <= in_1_d;
            in_2_q        <= in_2_d;
            tag_q         <= tag_d;
            result_q      <= result_d;
        end
    end

`ifdef MD_SCHED_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_div_q <= 1'b0;
        end else begin
            last_div_q <= last_div_d;
        end
    end
`endif

    assign busy               = (state_q != IDLE);
    assign md_req_op          = op_q;
    assign md_req_in_1_signed = in_1_signed_q;
    assign md_req_in_2_signed = in_2_signed_q;
    assign md_req_out_sel     = out_sel_q;
    assign md_req_in_1        = in_1_q;
    assign md_req_in_2        = in_2_q;
    assign cdb_tag            = tag_q;
    assign cdb_data           = result_q;

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - Directed self-checking testbench for md_sched

module tb_md_sched;

    localparam int TAG_W = 4;
    localparam int XLEN  = 32;
    localparam int OP_W  = 3;
    localparam int OS_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              busy;
    logic              mul_valid, mul_ready, mul_s1, mul_s2;
    logic [OP_W-1:0]   mul_op;
    logic [OS_W-1:0]   mul_out_sel;
    logic [XLEN-1:0]   mul_a, mul_b;
    logic [TAG_W-1:0]  mul_tag;
    logic              div_valid, div_ready, div_s1, div_s2;
    logic [OP_W-1:0]   div_op;
    logic [OS_W-1:0]   div_out_sel;
    logic [XLEN-1:0]   div_a, div_b;
    logic [TAG_W-1:0]  div_tag;
    logic              md_req_valid, md_req_ready, md_req_s1, md_req_s2;
    logic [OP_W-1:0]   md_req_op;
    logic [OS_W-1:0]   md_req_out_sel;
    logic [XLEN-1:0]   md_req_in_1, md_req_in_2;
    logic              md_resp_valid;
    logic [XLEN-1:0]   md_resp_result;
    logic              cdb_req, cdb_gnt;
    logic [TAG_W-1:0]  cdb_tag;
    logic [XLEN-1:0]   cdb_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    md_sched #(.TAG_W(TAG_W), .XLEN(XLEN), .MD_OP_WIDTH(OP_W), .MD_OUT_SEL_WIDTH(OS_W)) dut (
        .clk(clk), .reset(reset), .busy(busy),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_op(mul_op),
        .mul_in_1_signed(mul_s1), .mul_in_2_signed(mul_s2), .mul_out_sel(mul_out_sel),
        .mul_a(mul_a), .mul_b(mul_b), .mul_tag(mul_tag),
        .div_valid(div_valid), .div_ready(div_ready), .div_op(div_op),
        .div_in_1_signed(div_s1), .div_in_2_signed(div_s2), .div_out_sel(div_out_sel),
        .div_a(div_a), .div_b(div_b), .div_tag(div_tag),
        .md_req_valid(md_req_valid), .md_req_ready(md_req_ready), .md_req_op(md_req_op),
        .md_req_in_1_signed(md_req_s1), .md_req_in_2_signed(md_req_s2),
        .md_req_out_sel(md_req_out_sel), .md_req_in_1(md_req_in_1), .md_req_in_2(md_req_in_2),
        .md_resp_valid(md_resp_valid), .md_resp_result(md_resp_result),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic void chk(input string name, input bit ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s", name);
        end
    endfunction

    logic exp_div [4];

    initial begin
        reset = 1'b1;
        mul_valid = 0; mul_s1 = 0; mul_s2 = 0; mul_op = '0; mul_out_sel = '0;
        mul_a = '0; mul_b = '0; mul_tag = '0;
        div_valid = 0; div_s1 = 0; div_s2 = 0; div_op = '0; div_out_sel = '0;
        div_a = '0; div_b = '0; div_tag = '0;
        md_req_ready = 0; md_resp_valid = 0; md_resp_result = '0; cdb_gnt = 0;
        tick(); tick();
        #1;
        chk("rst_busy", busy === 1'b0);
        chk("rst_mul_ready", mul_ready === 1'b0);
        chk("rst_div_ready", div_ready === 1'b0);
        chk("rst_md_req_valid", md_req_valid === 1'b0);
        chk("rst_md_req_in_1", md_req_in_1 === 32'h0);
        chk("rst_md_req_op", md_req_op === 3'h0);
        chk("rst_cdb_req", cdb_req === 1'b0);
        chk("rst_cdb_tag", cdb_tag === 4'h0);
        chk("rst_cdb_data", cdb_data === 32'h0);
        reset = 1'b0;

        tick();
        mul_valid = 1; mul_a = 32'd7; mul_b = 32'd6; mul_tag = 4'd3;
        mul_op = 3'd1; mul_out_sel = 2'd2; mul_s1 = 1; mul_s2 = 0;
        #1;
        chk("t1_mul_ready", mul_ready === 1'b1);
        chk("t1_div_ready", div_ready === 1'b0);
        tick();
        mul_valid = 0; md_req_ready = 1;
        #1;
        chk("t1_busy", busy === 1'b1);
        chk("t1_md_req_valid", md_req_valid === 1'b1);
        chk("t1_in_1", md_req_in_1 === 32'd7);
        chk("t1_in_2", md_req_in_2 === 32'd6);
        chk("t1_op", md_req_op === 3'd1);
        chk("t1_out_sel", md_req_out_sel === 2'd2);
        chk("t1_s1", md_req_s1 === 1'b1);
        chk("t1_s2", md_req_s2 === 1'b0);
        tick();
        md_req_ready = 0; md_resp_valid = 1; md_resp_result = 32'd42;
        #1;
        chk("t1_wait_req_valid", md_req_valid === 1'b0);
        chk("t1_wait_cdb_req", cdb_req === 1'b0);
        tick();
        md_resp_valid = 0; md_resp_result = '0; cdb_gnt = 1;
        #1;
        chk("t1_cdb_req", cdb_req === 1'b1);
        chk("t1_cdb_tag", cdb_tag === 4'd3);
        chk("t1_cdb_data", cdb_data === 32'd42);
        tick();
        cdb_gnt = 0;
        #1;
        chk("t1_busy_fall", busy === 1'b0);
        chk("t1_cdb_req_fall", cdb_req === 1'b0);

        div_valid = 1; div_a = 32'hDEAD_BEEF; div_b = 32'h0000_0013; div_tag = 4'd5;
        div_op = 3'd4; div_out_sel = 2'd1; div_s1 = 1; div_s2 = 1;
        #1;
        chk("t2_div_ready", div_ready === 1'b1);
        tick();
        div_valid = 0; mul_valid = 1; mul_tag = 4'd9; mul_a = 32'd11; mul_b = 32'd12;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                md_req_ready = 1; md_resp_valid = 1; md_resp_result = 32'hFFFF_FFFF;
            end
            #1;
            chk("t2_md_req_valid", md_req_valid === 1'b1);
            chk("t2_in_1", md_req_in_1 === 32'hDEAD_BEEF);
            chk("t2_in_2", md_req_in_2 === 32'h0000_0013);
            chk("t2_op", md_req_op === 3'd4);
            chk("t2_mul_ready", mul_ready === 1'b0);
            chk("t2_div_ready", div_ready === 1'b0);
            tick();
        end
        md_req_ready = 0; md_resp_valid = 0; md_resp_result = '0;

        for (int i = 0; i < 5; i++) begin
            if (i == 4) cdb_gnt = 1;
            #1;
            chk("t3_cdb_req", cdb_req === 1'b1);
            chk("t3_cdb_tag", cdb_tag === 4'd5);
            chk("t3_cdb_data", cdb_data === 32'hFFFF_FFFF);
            chk("t3_mul_ready", mul_ready === 1'b0);
            tick();
        end
        cdb_gnt = 0;
        #1;
        chk("t3_accept_after_gnt", mul_ready === 1'b1);
        tick();
        mul_valid = 0; md_req_ready = 1;
        #1;
        chk("t4_issue_in_1", md_req_in_1 === 32'd11);
        tick();
        md_req_ready = 0;
        #1;
        chk("t4_in_wait", busy === 1'b1);

        reset = 1;
        tick();
        #1;
        chk("t4_rst_busy", busy === 1'b0);
        chk("t4_rst_md_req_valid", md_req_valid === 1'b0);
        chk("t4_rst_in_1", md_req_in_1 === 32'h0);
        chk("t4_rst_cdb_tag", cdb_tag === 4'h0);
        chk("t4_rst_cdb_data", cdb_data === 32'h0);
        reset = 0;
        tick();
        md_resp_valid = 1; md_resp_result = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_no_cdb_req", cdb_req === 1'b0);
            chk("t4_no_busy", busy === 1'b0);
            tick();
            md_resp_valid = 0;
        end
        chk("t4_no_result", cdb_data === 32'h0);

`ifdef MD_SCHED_RR_EN
        exp_div[0] = 1; exp_div[1] = 0; exp_div[2] = 1; exp_div[3] = 0;
`else
        exp_div[0] = 0; exp_div[1] = 0; exp_div[2] = 0; exp_div[3] = 0;
`endif
        mul_valid = 1; mul_tag = 4'd1; div_valid = 1; div_tag = 4'd2;
        md_req_ready = 1; md_resp_valid = 1; md_resp_result = 32'h55; cdb_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb_div_ready", div_ready === exp_div[k]);
            chk("arb_mul_ready", mul_ready === !exp_div[k]);
            tick();
            #1;
            chk("arb_issue", md_req_valid === 1'b1);
            tick();
            #1;
            chk("arb_cdb_req", cdb_req === 1'b1);
            chk("arb_cdb_tag", cdb_tag === (exp_div[k] ? 4'd2 : 4'd1));
            tick();
        end
        mul_valid = 0; div_valid = 0; md_req_ready = 0; md_resp_valid = 0; cdb_gnt = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
